// File: rtl/alu_mc_fsm_pkg.sv
// -----------------------------------------------------------------------------
// alu_mc_fsm_pkg
// Shared constants for the multi-cycle ALU: opcode encodings, FSM state
// encodings and a couple of small decode helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_mc_fsm_pkg;

   // Opcodes are fixed at three bits, giving eight defined operations
   localparam int OPCODE_W = 3;

   localparam logic [OPCODE_W-1:0] OP_ADD = 3'b000;
   localparam logic [OPCODE_W-1:0] OP_SUB = 3'b001;
   localparam logic [OPCODE_W-1:0] OP_SHR = 3'b010;
   localparam logic [OPCODE_W-1:0] OP_SHL = 3'b011;
   localparam logic [OPCODE_W-1:0] OP_AND = 3'b100;
   localparam logic [OPCODE_W-1:0] OP_OR  = 3'b101;
   localparam logic [OPCODE_W-1:0] OP_XOR = 3'b110;
   localparam logic [OPCODE_W-1:0] OP_MUL = 3'b111;

   // State encodings; the top builds its state enum from these so the
   // register width can follow the STATE_WIDTH parameter
   localparam int ENC_IDLE = 0;
   localparam int ENC_EXEC = 1;
   localparam int ENC_MUL  = 2;
   localparam int ENC_DONE = 3;

   // Multiply is the only operation that leaves EXEC for the MUL state
   function automatic logic opIsMul(input logic [OPCODE_W-1:0] op);
      return op == OP_MUL;
   endfunction

   // Shifts share the "everything shifted out" rule for large distances
   function automatic logic opIsShift(input logic [OPCODE_W-1:0] op);
      return (op == OP_SHR) || (op == OP_SHL);
   endfunction

endpackage

// File: rtl/alu_mc_fsm_if.sv
// -----------------------------------------------------------------------------
// alu_mc_fsm_if
// Request/result bundle between a controller (master) and the ALU (slave).
//   wr      master->slave  request, sampled only while the ALU is idle
//   opcode  master->slave  operation select
//   opa/opb master->slave  unsigned operands
//   busy    slave->master  ALU is working on an operation
//   done    slave->master  one-cycle pulse, res/status/zero valid
//   status  slave->master  carry / borrow / overflow flag
//   zero    slave->master  result is zero
//   res     slave->master  result, held until the next done
// -----------------------------------------------------------------------------
interface alu_mc_fsm_if #(
   parameter int OPCODE_WIDTH = 3,
   parameter int DATA_WIDTH   = 8
);

   logic                    wr;
   logic [OPCODE_WIDTH-1:0] opcode;
   logic [DATA_WIDTH-1:0]   opa;
   logic [DATA_WIDTH-1:0]   opb;
   logic                    busy;
   logic                    done;
   logic                    status;
   logic                    zero;
   logic [DATA_WIDTH-1:0]   res;

   // The controller side drives requests and watches results
   modport master (
      output wr, opcode, opa, opb,
      input  busy, done, status, zero, res
   );

   // The ALU side consumes requests and produces results
   modport slave (
      input  wr, opcode, opa, opb,
      output busy, done, status, zero, res
   );

endinterface

// File: rtl/alu_mc_fsm_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
// Iterative shift-add multiplier, one bit of b per clock.
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   load a/b and clear the accumulator
//   a, b   in   unsigned operands (DATA_WIDTH)
//   busy   out  steps still outstanding
//   last   out  the step on the coming edge is step DATA_WIDTH
//   prod   out  accumulator including the current step (2*DATA_WIDTH),
//               so on the last step it already holds the full product
// -----------------------------------------------------------------------------
module alu_mul_iter
   import alu_mc_fsm_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   a,
   input  logic [DATA_WIDTH-1:0]   b,
   output logic                    busy,
   output logic                    last,
   output logic [2*DATA_WIDTH-1:0] prod
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

   logic                    busy_q,   busy_d;
   logic [CW-1:0]           cnt_q,    cnt_d;
   logic [2*DATA_WIDTH-1:0] acc_q,    acc_d;
   logic [2*DATA_WIDTH-1:0] mcand_q,  mcand_d;
   logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*DATA_WIDTH-1:0] stepSum;

   // Each step adds the shifted multiplicand when the current low bit of the
   // multiplier is set, then shifts both; the step counter runs 0..W-1 and
   // the unit drops busy once the final step has been taken
   always_comb begin
      stepSum  = acc_q + (mplier_q[0] ? mcand_q : '0);
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      if (start) begin
         busy_d   = 1'b1;
         cnt_d    = '0;
         acc_d    = '0;
         mcand_d  = {{DATA_WIDTH{1'b0}}, a};
         mplier_d = b;
      end else if (busy_q) begin
         acc_d    = stepSum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         if (cnt_q == LAST_STEP) begin
            busy_d = 1'b0;
         end
      end
   end

   // Multiplier registers; reset abandons any multiply in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

   // The product is exposed one step early so the consumer can capture it
   // on the same edge that completes the multiply
   assign busy = busy_q;
   assign last = busy_q && (cnt_q == LAST_STEP);
   assign prod = busy_q ? stepSum : acc_q;

endmodule

// File: rtl/alu_mc_fsm.sv
// -----------------------------------------------------------------------------
// alu_mc_fsm
// Multi-cycle ALU with a Moore FSM (IDLE/EXEC/MUL/DONE). One request is
// accepted while idle; single-cycle ops finish two cycles after acceptance,
// multiply finishes DATA_WIDTH cycles later.
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset, overrides everything
//   bus     slave side of alu_mc_fsm_if (wr/opcode/opa/opb in,
//           busy/done/status/zero/res out)
// -----------------------------------------------------------------------------
module alu_mc_fsm
   import alu_mc_fsm_pkg::*;
#(
   parameter int OPCODE_WIDTH = 3,
   parameter int DATA_WIDTH   = 8,
   parameter int STATE_WIDTH  = 3
) (
   input  logic        clk,
   input  logic        rst,
   alu_mc_fsm_if.slave bus
);

   typedef enum logic [STATE_WIDTH-1:0] {
      S_IDLE = STATE_WIDTH'(ENC_IDLE),
      S_EXEC = STATE_WIDTH'(ENC_EXEC),
      S_MUL  = STATE_WIDTH'(ENC_MUL),
      S_DONE = STATE_WIDTH'(ENC_DONE)
   } aluState_e;

   localparam logic [DATA_WIDTH-1:0] WIDTH_VAL = DATA_WIDTH'(DATA_WIDTH);

   aluState_e               state_q,  state_d;
   logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
   logic [DATA_WIDTH-1:0]   opA_q,    opA_d;
   logic [DATA_WIDTH-1:0]   opB_q,    opB_d;
   logic [DATA_WIDTH-1:0]   res_q,    res_d;
   logic                    status_q, status_d;
   logic                    zero_q,   zero_d;

   logic [DATA_WIDTH-1:0]   aluRes;
   logic                    aluStatus;
   logic [DATA_WIDTH:0]     addWide;
   logic [2*DATA_WIDTH-1:0] shlWide;
   logic [2*DATA_WIDTH-1:0] shrWide;
   logic                    shiftAll;

   logic                    mulStart;
   logic                    mulBusy;
   logic                    mulLast;
   logic [2*DATA_WIDTH-1:0] mulProd;

   alu_mul_iter #(
      .DATA_WIDTH(DATA_WIDTH)
   ) uMul (
      .clk   (clk),
      .rst   (rst),
      .start (mulStart),
      .a     (opA_q),
      .b     (opB_q),
      .busy  (mulBusy),
      .last  (mulLast),
      .prod  (mulProd)
   );

   // Single-cycle datapath working only on the registered operands. Shifts
   // are done in a double-width word so the bits that fall off the end land
   // in the other half and can be OR-reduced into status. Distances of W or
   // more clear the result and report whether any set bit existed.
   always_comb begin
      addWide   = {1'b0, opA_q} + {1'b0, opB_q};
      shlWide   = {{DATA_WIDTH{1'b0}}, opA_q} << opB_q;
      shrWide   = {opA_q, {DATA_WIDTH{1'b0}}} >> opB_q;
      shiftAll  = opIsShift(opcode_q) && (opB_q >= WIDTH_VAL);
      aluRes    = '0;
      aluStatus = 1'b0;
      case (opcode_q)
         OP_ADD: begin
            aluRes    = addWide[DATA_WIDTH-1:0];
            aluStatus = addWide[DATA_WIDTH];
         end
         OP_SUB: begin
            aluRes    = opA_q - opB_q;
            aluStatus = opA_q < opB_q;
         end
         OP_SHR: begin
            if (shiftAll) begin
               aluStatus = |opA_q;
            end else begin
               aluRes    = shrWide[2*DATA_WIDTH-1:DATA_WIDTH];
               aluStatus = |shrWide[DATA_WIDTH-1:0];
            end
         end
         OP_SHL: begin
            if (shiftAll) begin
               aluStatus = |opA_q;
            end else begin
               aluRes    = shlWide[DATA_WIDTH-1:0];
               aluStatus = |shlWide[2*DATA_WIDTH-1:DATA_WIDTH];
            end
         end
         OP_AND:  aluRes = opA_q & opB_q;
         OP_OR:   aluRes = opA_q | opB_q;
         OP_XOR:  aluRes = opA_q ^ opB_q;
         default: aluRes = '0;
      endcase
   end

   // Next-state and register-update logic. Operands are captured only on the
   // accepting IDLE cycle, results only on entry to DONE. A MUL state whose
   // multiplier has gone idle without finishing (only reachable through a
   // corrupted state) falls back to IDLE instead of hanging.
   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      opA_d    = opA_q;
      opB_d    = opB_q;
      res_d    = res_q;
      status_d = status_q;
      zero_d   = zero_q;
      mulStart = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.wr) begin
               opcode_d = bus.opcode;
               opA_d    = bus.opa;
               opB_d    = bus.opb;
               state_d  = S_EXEC;
            end
         end
         S_EXEC: begin
            if (opIsMul(opcode_q)) begin
               mulStart = 1'b1;
               state_d  = S_MUL;
            end else begin
               res_d    = aluRes;
               status_d = aluStatus;
               zero_d   = (aluRes == '0);
               state_d  = S_DONE;
            end
         end
         S_MUL: begin
            if (mulLast) begin
               res_d    = mulProd[DATA_WIDTH-1:0];
               status_d = |mulProd[2*DATA_WIDTH-1:DATA_WIDTH];
               zero_d   = (mulProd[DATA_WIDTH-1:0] == '0);
               state_d  = S_DONE;
            end else if (!mulBusy) begin
               state_d  = S_IDLE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, operand and result registers; reset clears everything and
   // discards any operation in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         opcode_q <= '0;
         opA_q    <= '0;
         opB_q    <= '0;
         res_q    <= '0;
         status_q <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         opA_q    <= opA_d;
         opB_q    <= opB_d;
         res_q    <= res_d;
         status_q <= status_d;
         zero_q   <= zero_d;
      end
   end

   // Moore outputs come straight from the state and result registers
   assign bus.busy   = (state_q == S_EXEC) || (state_q == S_MUL) || (state_q == S_DONE);
   assign bus.done   = (state_q == S_DONE);
   assign bus.res    = res_q;
   assign bus.status = status_q;
   assign bus.zero   = zero_q;

endmodule
